// File: rtl/drive_arbiter.sv
// rtl/drive_arbiter.sv - motor drive arbiter between manual and autonomous paths
// Adds brake dead-time on mode change or reversal and a manual-command watchdog.
module drive_arbiter #(
  parameter int DEADTIME_CYC = 2_500_000,
  parameter int WATCHDOG_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       manual_on,
  input  logic       auto_on,
  input  logic [8:0] manual_dir,
  input  logic       cmd_strobe,
  input  logic [8:0] auto_dir,
  input  logic       auto_valid,
  output logic [8:0] motor_cmd,
  output logic       motor_en,
  output logic [1:0] state_o,
  output logic       wd_timeout
);

  localparam int MAXC = (DEADTIME_CYC > WATCHDOG_CYC) ? DEADTIME_CYC : WATCHDOG_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME_CYC - 1);
  localparam logic [CW-1:0] WD_LAST = CW'(WATCHDOG_CYC - 1);
  localparam logic [8:0]    STOP    = 9'h100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MANUAL = 2'b01,
    S_AUTO   = 2'b10,
    S_BRAKE  = 2'b11
  } state_t;

  function automatic logic [8:0] classify(input logic [8:0] v);
    if (v != 9'h000 && (v & (v - 9'h001)) == 9'h000) return v;
    return STOP;
  endfunction

  function automatic logic reversal(input logic [8:0] cur, input logic [8:0] nxt);
    logic cf, cr, nf, nr;
    cf = cur[0] | cur[4] | cur[5];
    cr = cur[1] | cur[6] | cur[7];
    nf = nxt[0] | nxt[4] | nxt[5];
    nr = nxt[1] | nxt[6] | nxt[7];
    return (cf & nr) | (cr & nf);
  endfunction

  state_t          state_q, state_d, target_q, target_d, from_q, from_d;
  logic [8:0]      cmd_q, cmd_d, held_q, held_d, pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d, en_q, en_d, wd_q, wd_d;
  logic [CW-1:0]   dt_cnt_q, dt_cnt_d, wd_cnt_q, wd_cnt_d;
  state_t          req;
  logic [8:0]      man_cls, auto_cls;
  logic            wd_expire;

  always_comb begin
    man_cls   = classify(manual_dir);
    auto_cls  = classify(auto_dir);
    req       = manual_on ? S_MANUAL : (auto_on ? S_AUTO : S_IDLE);
    wd_expire = !cmd_strobe && (wd_cnt_q >= WD_LAST);

    state_d      = state_q;
    target_d     = target_q;
    from_d       = from_q;
    cmd_d        = cmd_q;
    held_d       = held_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    en_d         = en_q;
    wd_d         = 1'b0;
    dt_cnt_d     = (dt_cnt_q != '0) ? dt_cnt_q - 1'b1 : '0;
    wd_cnt_d     = (wd_cnt_q != '1) ? wd_cnt_q + 1'b1 : wd_cnt_q;

    case (state_q)
      S_IDLE: begin
        cmd_d        = STOP;
        en_d         = 1'b0;
        pend_valid_d = 1'b0;
        if (req == S_MANUAL) begin
          state_d  = S_MANUAL;
          cmd_d    = man_cls;
          en_d     = 1'b1;
          wd_cnt_d = '0;
        end else if (req == S_AUTO) begin
          state_d = S_AUTO;
          held_d  = auto_valid ? auto_cls : STOP;
          cmd_d   = auto_valid ? auto_cls : STOP;
          en_d    = 1'b1;
        end
      end

      S_MANUAL: begin
        if (req == S_IDLE) begin
          state_d = S_IDLE;
          cmd_d   = STOP;
          en_d    = 1'b0;
        end else if (req == S_AUTO) begin
          state_d      = S_BRAKE;
          target_d     = S_AUTO;
          from_d       = S_MANUAL;
          pend_valid_d = 1'b0;
          cmd_d        = STOP;
          dt_cnt_d     = DT_LOAD;
        end else begin
          if (cmd_strobe) wd_cnt_d = '0;
          if (wd_expire) begin
            wd_d  = 1'b1;
            cmd_d = STOP;
          end else if (reversal(cmd_q, man_cls)) begin
            state_d      = S_BRAKE;
            target_d     = S_MANUAL;
            from_d       = S_MANUAL;
            pend_d       = man_cls;
            pend_valid_d = 1'b1;
            cmd_d        = STOP;
            dt_cnt_d     = DT_LOAD;
          end else begin
            cmd_d = man_cls;
          end
        end
      end

      S_AUTO: begin
        if (req == S_IDLE) begin
          state_d = S_IDLE;
          cmd_d   = STOP;
          en_d    = 1'b0;
        end else if (req == S_MANUAL) begin
          state_d      = S_BRAKE;
          target_d     = S_MANUAL;
          from_d       = S_AUTO;
          pend_valid_d = 1'b0;
          cmd_d        = STOP;
          dt_cnt_d     = DT_LOAD;
        end else if (auto_valid) begin
          if (reversal(cmd_q, auto_cls)) begin
            state_d      = S_BRAKE;
            target_d     = S_AUTO;
            from_d       = S_AUTO;
            pend_d       = auto_cls;
            pend_valid_d = 1'b1;
            cmd_d        = STOP;
            dt_cnt_d     = DT_LOAD;
          end else begin
            held_d = auto_cls;
            cmd_d  = auto_cls;
          end
        end else begin
          cmd_d = held_q;
        end
      end

      default: begin
        cmd_d = STOP;
        en_d  = 1'b1;
        if (req == S_IDLE) begin
          state_d      = S_IDLE;
          en_d         = 1'b0;
          pend_valid_d = 1'b0;
        end else begin
          target_d = req;
          // Newer autonomous commands supersede the one that caused the reversal.
          if (from_q == S_AUTO && auto_valid) begin
            pend_d       = auto_cls;
            pend_valid_d = 1'b1;
          end
          if (dt_cnt_q == '0) begin
            pend_valid_d = 1'b0;
            if (target_q == S_MANUAL) begin
              state_d  = S_MANUAL;
              cmd_d    = man_cls;
              wd_cnt_d = '0;
            end else begin
              state_d = S_AUTO;
              if (auto_valid) begin
                held_d = auto_cls;
                cmd_d  = auto_cls;
              end else if (from_q == S_AUTO && pend_valid_q) begin
                held_d = pend_q;
                cmd_d  = pend_q;
              end else begin
                held_d = STOP;
                cmd_d  = STOP;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= S_IDLE;
      from_q       <= S_IDLE;
      cmd_q        <= STOP;
      held_q       <= STOP;
      pend_q       <= STOP;
      pend_valid_q <= 1'b0;
      en_q         <= 1'b0;
      wd_q         <= 1'b0;
      dt_cnt_q     <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      from_q       <= from_d;
      cmd_q        <= cmd_d;
      held_q       <= held_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      en_q         <= en_d;
      wd_q         <= wd_d;
      dt_cnt_q     <= dt_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign motor_cmd  = cmd_q;
  assign motor_en   = en_q;
  assign state_o    = state_q;
  assign wd_timeout = wd_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// tb/tb_drive_arbiter.sv - directed self-checking bench for drive_arbiter
module tb_drive_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, manual_on, auto_on, cmd_strobe, auto_valid;
  logic [8:0] manual_dir, auto_dir, motor_cmd;
  logic       motor_en, wd_timeout;
  logic [1:0] state_o;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  drive_arbiter #(.DEADTIME_CYC(4), .WATCHDOG_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .manual_on(manual_on), .auto_on(auto_on),
    .manual_dir(manual_dir), .cmd_strobe(cmd_strobe), .auto_dir(auto_dir),
    .auto_valid(auto_valid), .motor_cmd(motor_cmd), .motor_en(motor_en),
    .state_o(state_o), .wd_timeout(wd_timeout)
  );

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic [8:0] cmd,
                            input logic en, input logic wd);
    check_eq({tag, ".state"}, {7'd0, state_o}, {7'd0, st});
    check_eq({tag, ".cmd"}, motor_cmd, cmd);
    check_eq({tag, ".en"}, {8'd0, motor_en}, {8'd0, en});
    check_eq({tag, ".wd"}, {8'd0, wd_timeout}, {8'd0, wd});
  endtask

  initial begin
    rst_n = 1'b0; manual_on = 1'b0; auto_on = 1'b0; cmd_strobe = 1'b0;
    auto_valid = 1'b0; manual_dir = 9'h100; auto_dir = 9'h100;
    step(); step();
    expect_out("reset", 2'b00, 9'h100, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("idle", 2'b00, 9'h100, 1'b0, 1'b0);

    // Enter manual driving forward
    manual_on = 1'b1; manual_dir = 9'h001; cmd_strobe = 1'b1;
    step(); cmd_strobe = 1'b0;
    expect_out("man_w", 2'b01, 9'h001, 1'b1, 1'b0);

    // w -> s reversal brakes for exactly four cycles
    manual_dir = 9'h002;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("rev_brake%0d", i), 2'b11, 9'h100, 1'b1, 1'b0);
    end
    step();
    expect_out("rev_done", 2'b01, 9'h002, 1'b1, 1'b0);
    manual_dir = 9'h004; step();
    expect_out("s_to_a", 2'b01, 9'h004, 1'b1, 1'b0);
    manual_dir = 9'h001; step();
    expect_out("a_to_w", 2'b01, 9'h001, 1'b1, 1'b0);
    manual_dir = 9'h004; step();
    expect_out("w_to_a", 2'b01, 9'h004, 1'b1, 1'b0);

    // Manual -> auto with dead-time, then an auto command
    manual_dir = 9'h001; step();
    manual_on = 1'b0; auto_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("mode_brake%0d", i), 2'b11, 9'h100, 1'b1, 1'b0);
    end
    step();
    expect_out("auto_entry", 2'b10, 9'h100, 1'b1, 1'b0);
    auto_dir = 9'h010; auto_valid = 1'b1;
    step(); auto_valid = 1'b0;
    expect_out("auto_wa", 2'b10, 9'h010, 1'b1, 1'b0);
    step();
    expect_out("auto_hold", 2'b10, 9'h010, 1'b1, 1'b0);

    // Back to manual; watchdog counts from manual entry
    manual_on = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("a2m_last_brake", {7'd0, state_o}, 9'd3);
    step();
    expect_out("a2m_entry", 2'b01, 9'h001, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      if (i == 15) expect_out("wd_pre", 2'b01, 9'h001, 1'b1, 1'b0);
    end
    step();
    expect_out("wd_expired", 2'b01, 9'h100, 1'b1, 1'b1);
    manual_dir = 9'h008; cmd_strobe = 1'b1;
    step(); cmd_strobe = 1'b0;
    expect_out("wd_cleared", 2'b01, 9'h008, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) step();
    expect_out("wd_edge_pre", 2'b01, 9'h008, 1'b1, 1'b0);
    cmd_strobe = 1'b1;
    step(); cmd_strobe = 1'b0;
    expect_out("wd_strobe_wins", 2'b01, 9'h008, 1'b1, 1'b0);

    // Invalid vector, priority, drop to idle mid-brake
    manual_dir = 9'h003; step();
    expect_out("invalid", 2'b01, 9'h100, 1'b1, 1'b0);
    auto_on = 1'b1; step();
    expect_out("both_high", 2'b01, 9'h100, 1'b1, 1'b0);
    manual_dir = 9'h001; step();
    check_eq("pre_rev_w", motor_cmd, 9'h001);
    manual_dir = 9'h002; step();
    check_eq("brake_again", {7'd0, state_o}, 9'd3);
    manual_on = 1'b0; auto_on = 1'b0; step();
    expect_out("drop_idle", 2'b00, 9'h100, 1'b0, 1'b0);

    // Asynchronous reset mid-brake
    manual_on = 1'b1; manual_dir = 9'h001; step();
    expect_out("re_enter", 2'b01, 9'h001, 1'b1, 1'b0);
    manual_dir = 9'h002; step();
    check_eq("brake_for_rst", {7'd0, state_o}, 9'd3);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 2'b00, 9'h100, 1'b0, 1'b0);
    manual_on = 1'b0;
    step(); rst_n = 1'b1;
    step();
    expect_out("post_rst", 2'b00, 9'h100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
